// File: rtl/axis_quad_rx_merger_pkg.sv
// Shared types and constants for the four-lane receive stream merger.
package axis_quad_rx_merger_pkg;

    typedef enum logic {MERGE_IDLE, MERGE_BUSY} merge_state_t;

    localparam int NUM_QSGMII_LANES = 4;
    localparam int LANE_W           = 2;

    // Lane visited at position 'step' of the round-robin scan after 'last'.
    function automatic logic [LANE_W-1:0] rr_lane(input logic [LANE_W-1:0] last, input int step);
        return last + LANE_W'(step);
    endfunction

endpackage

// File: rtl/axis_merger_out_reg.sv
// Two-entry output skid register; push_ready depends only on local state, never on pop_ready.
module axis_merger_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready
);

    logic             main_valid_reg, skid_valid_reg;
    logic [WIDTH-1:0] main_data_reg, skid_data_reg;
    logic             main_free, push;

    assign main_free  = !main_valid_reg || pop_ready;
    assign push       = push_valid && !skid_valid_reg;
    assign push_ready = !skid_valid_reg;
    assign pop_valid  = main_valid_reg;
    assign pop_data   = main_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (main_free) begin
            if (skid_valid_reg) begin
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= push;
            end
        end else if (push) begin
            skid_valid_reg <= 1'b1;
        end
    end

    // Payload registers carry no reset: they are only observed behind a valid flag.
    always_ff @(posedge clk) begin
        if (main_free) begin
            if (skid_valid_reg) begin
                main_data_reg <= skid_data_reg;
            end else if (push) begin
                main_data_reg <= push_data;
            end
        end else if (push) begin
            skid_data_reg <= push_data;
        end
    end

endmodule

// File: rtl/axis_quad_rx_merger.sv
// Packet-atomic round-robin merge of four lane streams into one, tagging beats with tid.
// Optional per-lane completed-frame counters are built when QUAD_MERGER_STATS_EN is defined.
module axis_quad_rx_merger
    import axis_quad_rx_merger_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int STAT_WIDTH = 32
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NUM_QSGMII_LANES-1:0]                       rx_tvalid,
    output logic [NUM_QSGMII_LANES-1:0]                       rx_tready,
    input  logic [NUM_QSGMII_LANES-1:0][DATA_WIDTH-1:0]       rx_tdata,
    input  logic [NUM_QSGMII_LANES-1:0][DATA_WIDTH/8-1:0]     rx_tkeep,
    input  logic [NUM_QSGMII_LANES-1:0][USER_WIDTH-1:0]       rx_tuser,
    input  logic [NUM_QSGMII_LANES-1:0]                       rx_tlast,
    output logic                                              out_tvalid,
    input  logic                                              out_tready,
    output logic [DATA_WIDTH-1:0]                             out_tdata,
    output logic [DATA_WIDTH/8-1:0]                           out_tkeep,
    output logic [USER_WIDTH-1:0]                             out_tuser,
    output logic                                              out_tlast,
    output logic [LANE_W-1:0]                                 out_tid
`ifdef QUAD_MERGER_STATS_EN
    ,
    output logic [NUM_QSGMII_LANES-1:0][STAT_WIDTH-1:0]       frame_count
`endif
);

    localparam int PAYLOAD_W = LANE_W + 1 + USER_WIDTH + DATA_WIDTH/8 + DATA_WIDTH;

    merge_state_t          state_reg, state_next;
    logic [LANE_W-1:0]     last_grant_reg, last_grant_next;
    logic                  sel_valid, sel_last, out_ready, accept, found;
    logic [PAYLOAD_W-1:0]  sel_payload, out_payload;

    // In BUSY, last_grant_reg is the lane currently owning the output.
    assign sel_valid   = (state_reg == MERGE_BUSY) && rx_tvalid[last_grant_reg];
    assign sel_last    = rx_tlast[last_grant_reg];
    assign accept      = sel_valid && out_ready;
    assign sel_payload = {last_grant_reg, sel_last, rx_tuser[last_grant_reg],
                          rx_tkeep[last_grant_reg], rx_tdata[last_grant_reg]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QSGMII_LANES; gi++) begin : g_ready
            assign rx_tready[gi] = (state_reg == MERGE_BUSY) &&
                                   (last_grant_reg == LANE_W'(gi)) && out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= MERGE_IDLE;
            last_grant_reg <= LANE_W'(NUM_QSGMII_LANES - 1);
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        found           = 1'b0;
        case (state_reg)
            MERGE_IDLE: begin
                for (int i = 1; i <= NUM_QSGMII_LANES; i++) begin
                    if (!found && rx_tvalid[rr_lane(last_grant_reg, i)]) begin
                        found           = 1'b1;
                        last_grant_next = rr_lane(last_grant_reg, i);
                        state_next      = MERGE_BUSY;
                    end
                end
            end
            MERGE_BUSY: begin
                if (accept && sel_last) begin
                    state_next = MERGE_IDLE;
                end
            end
            default: state_next = MERGE_IDLE;
        endcase
    end

    axis_merger_out_reg #(
        .WIDTH(PAYLOAD_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(sel_valid),
        .push_data (sel_payload),
        .push_ready(out_ready),
        .pop_valid (out_tvalid),
        .pop_data  (out_payload),
        .pop_ready (out_tready)
    );

    assign {out_tid, out_tlast, out_tuser, out_tkeep, out_tdata} = out_payload;

`ifdef QUAD_MERGER_STATS_EN
    generate
        for (gi = 0; gi < NUM_QSGMII_LANES; gi++) begin : g_stats
            logic [STAT_WIDTH-1:0] count_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (accept && sel_last && (last_grant_reg == LANE_W'(gi))) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
            assign frame_count[gi] = count_reg;
        end
    endgenerate
`else
    logic unused_stat_width;
    assign unused_stat_width = (STAT_WIDTH > 0);
`endif

endmodule
